// File: rtl/memss_pkg.sv
// rtl/memss_pkg.sv - shared memory-subsystem types: request sideband and arbiter direction.
package memss_pkg;

    typedef struct packed {
        logic [3:0] qos;
        logic [7:0] tag;
    } user_s;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_dir_e;

    function automatic arb_dir_e arb_flip(input arb_dir_e d);
        return (d == ARB_RD) ? ARB_WR : ARB_RD;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - round-robin picker: first request at or after ptr, wrapping.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            // ptr is always < N, so a single subtraction wraps the offset
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            pos = sum[ID_W-1:0];
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - direction-aware round-robin memory port arbiter with registered output.
// Optional per-master grant counters are built when MEM_ARB_GNT_CNT_EN is defined.
module mem_arbiter_rr
    import memss_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 1024,
    parameter int MAX_BURST   = 4,
    parameter int CNT_WIDTH   = 32,
    localparam int ID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic [ADDR_WIDTH-1:0]  rd_addr [NUM_MASTERS],
    input  user_s                  rd_user [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0] rd_addr_val,
    output logic [NUM_MASTERS-1:0] rd_addr_rdy,
    input  logic [ADDR_WIDTH-1:0]  wr_addr [NUM_MASTERS],
    input  user_s                  wr_user [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0]  wr_data [NUM_MASTERS],
    input  logic [STRB_W-1:0]      wr_strb [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0] wr_addr_data_val,
    output logic [NUM_MASTERS-1:0] wr_addr_data_rdy,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output user_s                  out_user,
    output logic [DATA_WIDTH-1:0]  out_wr_data,
    output logic [STRB_W-1:0]      out_wr_strb,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_rd_en,
    output logic                   out_wr_en,
    output logic                   out_val,
`ifdef MEM_ARB_GNT_CNT_EN
    output logic [CNT_WIDTH-1:0]   gnt_cnt [NUM_MASTERS],
    input  logic                   cnt_clr,
`endif
    input  logic                   out_rdy
);

    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    arb_dir_e           state_q, state_d, dir;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]    rd_ptr_q, wr_ptr_q;

    logic [NUM_MASTERS-1:0] rd_gnt, wr_gnt;
    logic [ID_W-1:0]        rd_idx, wr_idx, win_idx;
    logic                   rd_found, wr_found;
    logic                   rd_any, wr_any, cur_any, opp_any, burst_full;
    logic                   load, grant;

    rr_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_rd_pick (
        .req   (rd_addr_val),
        .ptr   (rd_ptr_q),
        .gnt   (rd_gnt),
        .idx   (rd_idx),
        .found (rd_found)
    );

    rr_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_wr_pick (
        .req   (wr_addr_data_val),
        .ptr   (wr_ptr_q),
        .gnt   (wr_gnt),
        .idx   (wr_idx),
        .found (wr_found)
    );

    always_comb begin
        rd_any     = |rd_addr_val;
        wr_any     = |wr_addr_data_val;
        cur_any    = (state_q == ARB_RD) ? rd_any : wr_any;
        opp_any    = (state_q == ARB_RD) ? wr_any : rd_any;
        burst_full = (burst_cnt_q == BURST_W'(MAX_BURST));
        // Turn around when idle in this direction or the burst budget is spent
        dir        = (opp_any && (!cur_any || burst_full)) ? arb_flip(state_q) : state_q;
        load       = !hold && (!out_val || out_rdy);
        grant      = !rst && load && ((dir == ARB_RD) ? rd_found : wr_found);
        win_idx    = (dir == ARB_RD) ? rd_idx : wr_idx;

        rd_addr_rdy      = (grant && dir == ARB_RD) ? rd_gnt : '0;
        wr_addr_data_rdy = (grant && dir == ARB_WR) ? wr_gnt : '0;

        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (grant) begin
            state_d = dir;
            if (dir != state_q) begin
                burst_cnt_d = BURST_W'(1);
            end else if (!burst_full) begin
                burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_RD;
            burst_cnt_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            if (grant && dir == ARB_RD) begin
                rd_ptr_q <= (rd_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : rd_idx + ID_W'(1);
            end
            if (grant && dir == ARB_WR) begin
                wr_ptr_q <= (wr_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : wr_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_val     <= 1'b0;
            out_rd_en   <= 1'b0;
            out_wr_en   <= 1'b0;
            out_id      <= '0;
            out_addr    <= '0;
            out_user    <= '0;
            out_wr_data <= '0;
            out_wr_strb <= '0;
        end else if (load) begin
            out_val <= grant;
            if (grant) begin
                out_id    <= win_idx;
                out_rd_en <= (dir == ARB_RD);
                out_wr_en <= (dir == ARB_WR);
                if (dir == ARB_RD) begin
                    out_addr    <= rd_addr[win_idx];
                    out_user    <= rd_user[win_idx];
                    out_wr_data <= '0;
                    out_wr_strb <= '0;
                end else begin
                    out_addr    <= wr_addr[win_idx];
                    out_user    <= wr_user[win_idx];
                    out_wr_data <= wr_data[win_idx];
                    out_wr_strb <= wr_strb[win_idx];
                end
            end
        end
    end

`ifdef MEM_ARB_GNT_CNT_EN
    // A clear coinciding with a grant still records that grant
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (rst) begin
                gnt_cnt[i] <= '0;
            end else if (cnt_clr) begin
                gnt_cnt[i] <= (grant && win_idx == ID_W'(i)) ? CNT_WIDTH'(1) : '0;
            end else if (grant && win_idx == ID_W'(i) && !(&gnt_cnt[i])) begin
                gnt_cnt[i] <= gnt_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Round-robin, direction-aware successor to the fixed-priority memory-port arbiter. It sits in front of a single-ported memory line bank, between `NUM_MASTERS` read/write request channels and one downstream memory command port. Arbitration is per-direction round-robin with a read/write burst limit to bound turnaround and starvation. A registered output stage carries a full valid/ready handshake, so a master is acknowledged only when its command is actually accepted.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of request masters, 1..16.
- `ADDR_WIDTH`, 10: memory line address width.
- `DATA_WIDTH`, 1024: memory line width (multiple of 8).
- `MAX_BURST`, 4: max consecutive same-direction grants while the opposite direction is pending, ≥1.
- `CNT_WIDTH`, 32: grant counter width (`MEM_ARB_GNT_CNT_EN` only).

Ports (`ID_W = max(1, $clog2(NUM_MASTERS))`):
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `hold` in 1: block new grants; output register keeps its contents.
- `rd_addr[NUM_MASTERS]` in ADDR_WIDTH: read addresses.
- `rd_user[NUM_MASTERS]` in `memss_pkg::user_s`: read sideband.
- `rd_addr_val` in NUM_MASTERS: read request valids.
- `rd_addr_rdy` out NUM_MASTERS: read accept; one-hot or zero.
- `wr_addr[NUM_MASTERS]` in ADDR_WIDTH; `wr_user[NUM_MASTERS]` in `user_s`; `wr_data[NUM_MASTERS]` in DATA_WIDTH; `wr_strb[NUM_MASTERS]` in DATA_WIDTH/8.
- `wr_addr_data_val` in NUM_MASTERS; `wr_addr_data_rdy` out NUM_MASTERS: write handshake; rdy is one-hot or zero.
- `out_addr` out ADDR_WIDTH; `out_user` out `user_s`; `out_wr_data` out DATA_WIDTH; `out_wr_strb` out DATA_WIDTH/8.
- `out_id` out ID_W: granted master index.
- `out_rd_en`, `out_wr_en` out 1: command type; exactly one is set when `out_val` is high.
- `out_val` out 1, `out_rdy` in 1: downstream handshake.
- `gnt_cnt[NUM_MASTERS]` out CNT_WIDTH; `cnt_clr` in 1: present only with the macro.

## Operation
- `load = !hold && (!out_val || out_rdy)`. A grant happens only when `load` is high and some valid is set. At most one grant per cycle, across all masters and both directions.
- Direction FSM, states `RD` and `WR`; reset state is `RD`. The effective direction `dir` equals the state, except it flips to the opposite direction when either:
  - the current direction has no valid requests and the opposite direction has one; or
  - `burst_cnt == MAX_BURST` and the opposite direction has a valid request.
- On each grant the state becomes `dir`. `burst_cnt` is set to 1 if the direction changed; otherwise it increments, saturating at `MAX_BURST`. `burst_cnt` resets to 0.
- Round-robin uses separate `rd_ptr` and `wr_ptr` (reset 0). The grant goes to the first valid at or after the pointer, wrapping modulo `NUM_MASTERS`. On a grant, ptr becomes `(winner+1) mod NUM_MASTERS`. The pointer of the non-granted direction is unchanged.
- The granted master sees its `*_rdy` high in the same cycle; the transfer completes on val&&rdy. Masters must hold payload stable while val is high. A val may drop without a handshake.
- The output register loads addr, user, id, and direction from the winner. On read grants, `out_wr_data` and `out_wr_strb` load 0.
- `out_val` behaviour:
  - set on load with a grant;
  - cleared on load without a grant;
  - otherwise held, including while `hold` is high.
- Reset values: `out_val`, `out_rd_en`, `out_wr_en`, `out_id`, `out_addr`, `out_user`, `out_wr_data`, `out_wr_strb`, and `gnt_cnt` are all 0. `*_rdy` are 0 during reset.
- `rst` mid-operation discards any held command (no handshake is issued) and returns the FSM, pointers, and burst counter to reset state.

## Timing
- Latency: master handshake in cycle N gives `out_val` in cycle N+1. Sustained throughput is 1 command/cycle while `out_rdy` is high.
- `*_rdy` is combinational from `*_val`, `hold`, `out_val`, `out_rdy`, and registered state. No combinational path exists from `*_val` to `out_*`.
- With `out_val=1` and `out_rdy=0`, all `*_rdy` are 0 and outputs are stable.
- Simultaneous `cnt_clr` and grant: the counter becomes 1 for the granted master and 0 for the others.

## Configuration
- `MEM_ARB_GNT_CNT_EN` defined:
  - per-master `gnt_cnt` counts handshakes (read plus write) and saturates at all-ones;
  - `cnt_clr` zeroes all counters synchronously.
- Undefined: `gnt_cnt` and `cnt_clr` ports and their logic are absent. Arbitration behaviour is identical in both builds.

## Structure
- `memss_pkg` holds `user_s` and a new `arb_dir_e` enum {`ARB_RD`, `ARB_WR`}.
- Sub-module `rr_pick`: parametrised NUM_MASTERS round-robin picker with inputs (req, ptr) and outputs (one-hot gnt, idx, found). It is instantiated twice, once for reads and once for writes.

## Test plan
- Reset, then master 2 reads addr 0x15 with `out_rdy=1`: `rd_addr_rdy=4'b0100` in cycle 1; `out_val=1`, `out_addr=0x15`, `out_id=2`, `out_rd_en=1` in cycle 2.
- All 4 read valids held for 8 cycles: grant order 0,1,2,3,0,1,2,3; `rd_ptr` wraps to 0.
- 4 reads and 4 writes pending continuously, `MAX_BURST=4`: grant pattern is 4 reads then 4 writes, repeating; `burst_cnt` never exceeds 4.
- `out_rdy=0` for 3 cycles with a command held: `out_*` stable, all rdy 0; on `out_rdy=1` the next grant occurs in the same cycle.
- `hold=1` with requests pending: no rdy and `out_val` unchanged; `rst` asserted mid-hold clears `out_val`, and the first grant after reset is read master 0.
- Macro on: 5 grants to master 1, then `cnt_clr` together with a grant to master 1: `gnt_cnt[1]` reads 5, then 1.
